ac97_cmd_arbiter: RTL

AC97_CMD_ARBITER -- requirements
Module: ac97_cmd_arbiter

---
 rtl/ac97_pkg.sv | 24 ++
 rtl/ac97_rr_arb2.sv | 21 ++
 rtl/ac97_cmd_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ac97_pkg.sv
// Shared definitions for the AC-link command arbiter: slot/field widths,
// FSM state encoding and the default read-response timeout.
package ac97_pkg;

    localparam int unsigned SlotW            = 20;
    localparam int unsigned AddrW            = 7;
    localparam int unsigned DataW            = 16;
    localparam int unsigned TimeoutFramesDef = 4;
    localparam int unsigned CntW             = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitResp,
        StDone
    } ac97_state_e;

    // Command address slot: bit 19 is the read flag, [18:12] the register index.
    function automatic logic [SlotW-1:0] cmd_addr_slot(input logic             wr,
                                                       input logic [AddrW-1:0] addr);
        return {~wr, addr, 12'h000};
    endfunction

endpackage

// File: rtl/ac97_rr_arb2.sv
// Two-way round-robin grant. prio_i names the requester that wins a tie;
// the parent flips it to the loser after every grant.
module ac97_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    // Prefer the priority requester, otherwise take whichever one is asking.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_idx_o   = 1'b0;
        if (req_i[prio_i]) begin
            gnt_idx_o = prio_i;
        end else if (req_i[~prio_i]) begin
            gnt_idx_o = ~prio_i;
        end
    end

endmodule

// File: rtl/ac97_cmd_arbiter.sv
// AC97 codec register command arbiter: shares slots 1/2 of the AC-link between
// two requesters, one command outstanding at a time, and matches read
// responses by echoed register address.
// Optional feature: define AC97_CMD_TIMEOUT_EN to fail reads that get no
// response within TIMEOUT_FRAMES frames (req_err=1, rdata=16'hFFFF).
module ac97_cmd_arbiter
    import ac97_pkg::*;
#(
    parameter int unsigned TIMEOUT_FRAMES = TimeoutFramesDef
) (
    input  logic                   ac97_bitclk,
    input  logic                   ac97_rst_b,
    input  logic                   ac97_strobe,
    input  logic [SlotW-1:0]       ac97_in_slot1,
    input  logic                   ac97_in_slot1_valid,
    input  logic [SlotW-1:0]       ac97_in_slot2,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_write,
    input  logic [2*AddrW-1:0]     req_addr,
    input  logic [2*DataW-1:0]     req_wdata,
    output logic [1:0]             req_ack,
    output logic [1:0]             req_err,
    output logic [DataW-1:0]       rdata,
    output logic [SlotW-1:0]       ac97_out_slot1,
    output logic                   ac97_out_slot1_valid,
    output logic [SlotW-1:0]       ac97_out_slot2,
    output logic                   ac97_out_slot2_valid,
    output logic                   busy
);

    if (TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > 15) begin : g_bad_timeout
        $error("TIMEOUT_FRAMES must be in 1..15");
    end

    ac97_state_e        state_q, state_d;
    logic [SlotW-1:0]   slot1_q, slot1_d;
    logic               slot1_vld_q, slot1_vld_d;
    logic [SlotW-1:0]   slot2_q, slot2_d;
    logic               slot2_vld_q, slot2_vld_d;
    logic [1:0]         ack_q, ack_d;
    logic [DataW-1:0]   rdata_q, rdata_d;
    logic               gnt_idx_q, gnt_idx_d;
    logic               prio_q, prio_d;
    logic               wr_q, wr_d;
    logic [AddrW-1:0]   addr_q, addr_d;
`ifdef AC97_CMD_TIMEOUT_EN
    logic [1:0]         err_q, err_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
`endif

    logic               arb_valid;
    logic               arb_idx;
    logic               resp_hit;
    logic [AddrW-1:0]   sel_addr;
    logic [DataW-1:0]   sel_wdata;
    logic               sel_write;
    logic               unused_in_bits;

    ac97_rr_arb2 u_arb (
        .req_i       (req_valid),
        .prio_i      (prio_q),
        .gnt_valid_o (arb_valid),
        .gnt_idx_o   (arb_idx)
    );

    // Only the echoed address field and the 16 data bits matter on receive.
    assign unused_in_bits = ^{ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};

    assign sel_addr  = arb_idx ? req_addr[2*AddrW-1:AddrW] : req_addr[AddrW-1:0];
    assign sel_wdata = arb_idx ? req_wdata[2*DataW-1:DataW] : req_wdata[DataW-1:0];
    assign sel_write = req_write[arb_idx];
    assign resp_hit  = ac97_in_slot1_valid && (ac97_in_slot1[18:12] == addr_q);

    // Next-state and registered-output logic; transitions only on frame strobes,
    // except DONE which always falls back to IDLE after its single ack cycle.
    always_comb begin
        state_d     = state_q;
        slot1_d     = slot1_q;
        slot1_vld_d = slot1_vld_q;
        slot2_d     = slot2_q;
        slot2_vld_d = slot2_vld_q;
        ack_d       = 2'b00;
        rdata_d     = rdata_q;
        gnt_idx_d   = gnt_idx_q;
        prio_d      = prio_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
`ifdef AC97_CMD_TIMEOUT_EN
        err_d       = err_q;
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (ac97_strobe && arb_valid) begin
                    gnt_idx_d   = arb_idx;
                    prio_d      = ~arb_idx;
                    wr_d        = sel_write;
                    addr_d      = sel_addr;
                    slot1_d     = cmd_addr_slot(sel_write, sel_addr);
                    slot1_vld_d = 1'b1;
                    slot2_d     = sel_write ? {sel_wdata, 4'h0} : '0;
                    slot2_vld_d = sel_write;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (ac97_strobe) begin
                    slot1_d     = '0;
                    slot1_vld_d = 1'b0;
                    slot2_d     = '0;
                    slot2_vld_d = 1'b0;
                    if (wr_q) begin
                        ack_d   = 2'b01 << gnt_idx_q;
                        state_d = StDone;
                    end else begin
`ifdef AC97_CMD_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                        state_d = StWaitResp;
                    end
                end
            end
            StWaitResp: begin
                if (ac97_strobe) begin
                    if (resp_hit) begin
                        rdata_d = ac97_in_slot2[19:4];
                        ack_d   = 2'b01 << gnt_idx_q;
                        state_d = StDone;
                    end
`ifdef AC97_CMD_TIMEOUT_EN
                    // This strobe is the TIMEOUT_FRAMES-th without a match.
                    else if (cnt_q == CntW'(TIMEOUT_FRAMES - 1)) begin
                        rdata_d = 16'hFFFF;
                        err_d   = 2'b01 << gnt_idx_q;
                        ack_d   = 2'b01 << gnt_idx_q;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            StDone: begin
`ifdef AC97_CMD_TIMEOUT_EN
                err_d   = 2'b00;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset drops any in-flight command silently.
    always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            state_q     <= StIdle;
            slot1_q     <= '0;
            slot1_vld_q <= 1'b0;
            slot2_q     <= '0;
            slot2_vld_q <= 1'b0;
            ack_q       <= 2'b00;
            rdata_q     <= '0;
            gnt_idx_q   <= 1'b0;
            prio_q      <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
`ifdef AC97_CMD_TIMEOUT_EN
            err_q       <= 2'b00;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            slot1_q     <= slot1_d;
            slot1_vld_q <= slot1_vld_d;
            slot2_q     <= slot2_d;
            slot2_vld_q <= slot2_vld_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            gnt_idx_q   <= gnt_idx_d;
            prio_q      <= prio_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
`ifdef AC97_CMD_TIMEOUT_EN
            err_q       <= err_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ack              = ack_q;
`ifdef AC97_CMD_TIMEOUT_EN
    assign req_err              = err_q;
`else
    assign req_err              = 2'b00;
`endif
    assign rdata                = rdata_q;
    assign ac97_out_slot1       = slot1_q;
    assign ac97_out_slot1_valid = slot1_vld_q;
    assign ac97_out_slot2       = slot2_q;
    assign ac97_out_slot2_valid = slot2_vld_q;
    assign busy                 = (state_q != StIdle);

endmodule
